// File: rtl/vga_text_rd.sv
// vga_text_rd: display-side reader for the text-mode char/attr RAMs and
// font ROM; a fixed 4-cycle pipeline producing one color index per pixel.
module vga_text_rd (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic        cursor_on,
  input  logic [10:0] cursor_addr,
  input  logic [3:0]  cursor_start,
  input  logic [3:0]  cursor_end,
  output logic [10:0] text_addr,
  output logic        text_cs,
  input  logic [7:0]  char_data,
  input  logic [7:0]  attr_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  color,
  output logic        video_on_out
);

  logic [4:0]  row;
  logic [10:0] addr;
  logic        cur_hit;
  logic        top;
  logic        top_d;
  logic [4:0]  blink_cnt;

  logic [3:0]  line0, line1;
  logic [2:0]  px0, px1, px2, px3;
  logic        von0, von1, von2, video_on_d;
  logic        cur0, cur1, cur2, cur3;
  logic [7:0]  attr2, attr3;

  logic        bit_on;
  logic [3:0]  fg;
  logic [3:0]  bg;
  logic [3:0]  pixel;

  // row*80 as row*64 + row*16
  always_comb begin
    row  = v_count[8:4];
    addr = {row, 6'b0}
         + {2'b0, row, 4'b0}
         + {4'b0, h_count[9:3]};
    cur_hit = cursor_on
           && (addr == cursor_addr)
           && (cursor_start <= v_count[3:0])
           && (v_count[3:0] <= cursor_end);
    top = (h_count == 10'd0)
       && (v_count == 10'd0);
  end

  always_comb begin
    bit_on = font_data[3'd7 - px3];
    fg     = attr3[3:0];
    bg     = {1'b0, attr3[6:4]};
    pixel  = bit_on ? fg : bg;
    if (cur3 && blink_cnt[3])
      pixel = fg;
    else if (attr3[7] && blink_cnt[4])
      pixel = bg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_addr    <= '0;
      text_cs      <= 1'b0;
      font_addr    <= '0;
      color        <= '0;
      video_on_out <= 1'b0;
      blink_cnt    <= '0;
      top_d        <= 1'b0;
      line0        <= '0;
      line1        <= '0;
      px0          <= '0;
      px1          <= '0;
      px2          <= '0;
      px3          <= '0;
      von0         <= 1'b0;
      von1         <= 1'b0;
      von2         <= 1'b0;
      video_on_d   <= 1'b0;
      cur0         <= 1'b0;
      cur1         <= 1'b0;
      cur2         <= 1'b0;
      cur3         <= 1'b0;
      attr2        <= '0;
      attr3        <= '0;
    end else begin
      text_addr <= addr;
      text_cs   <= video_on;
      line0     <= v_count[3:0];
      px0       <= h_count[2:0];
      von0      <= video_on;
      cur0      <= cur_hit;

      line1 <= line0;
      px1   <= px0;
      von1  <= von0;
      cur1  <= cur0;

      font_addr <= {char_data, line1};
      attr2     <= attr_data;
      px2       <= px1;
      von2      <= von1;
      cur2      <= cur1;

      attr3      <= attr2;
      px3        <= px2;
      video_on_d <= von2;
      cur3       <= cur2;

      color        <= video_on_d ? pixel : 4'h0;
      video_on_out <= video_on_d;

      top_d <= top;
      if (top && !top_d)
        blink_cnt <= blink_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_vga_text_rd.sv
// tb_vga_text_rd: scoreboard bench for vga_text_rd with behavioural
// char/attr RAM and font ROM models.
module tb_vga_text_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic        video_on = 1'b0;
  logic        cursor_on = 1'b0;
  logic [10:0] cursor_addr = '0;
  logic [3:0]  cursor_start = '0;
  logic [3:0]  cursor_end = '0;
  logic [10:0] text_addr;
  logic        text_cs;
  logic [7:0]  char_data = '0;
  logic [7:0]  attr_data = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [3:0]  color;
  logic        video_on_out;

  logic [7:0] char_mem [2048];
  logic [7:0] attr_mem [2048];
  logic [7:0] font_mem [4096];

  typedef struct {
    int       due;
    bit       von;
    bit       pbit;
    bit       blk;
    bit       cur;
    bit [3:0] fg;
    bit [3:0] bg;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [4:0] blink_m = '0;
  bit top_prev = 1'b0;

  vga_text_rd dut (
    .clk(clk),
    .rst(rst),
    .h_count(h_count),
    .v_count(v_count),
    .video_on(video_on),
    .cursor_on(cursor_on),
    .cursor_addr(cursor_addr),
    .cursor_start(cursor_start),
    .cursor_end(cursor_end),
    .text_addr(text_addr),
    .text_cs(text_cs),
    .char_data(char_data),
    .attr_data(attr_data),
    .font_addr(font_addr),
    .font_data(font_data),
    .color(color),
    .video_on_out(video_on_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (text_cs) begin
      char_data <= char_mem[text_addr];
      attr_data <= attr_mem[text_addr];
    end
    font_data <= font_mem[font_addr];
  end

  // Reference: blink counter model plus scoreboard pop/compare.
  initial begin : monitor
    exp_t e;
    logic [4:0] bu;
    logic [3:0] pix;
    logic [3:0] ec;
    bit top;
    forever begin
      @(posedge clk);
      cyc++;
      bu = blink_m;
      if (rst) begin
        blink_m = '0;
        top_prev = 1'b0;
      end else begin
        top = (h_count == 0) && (v_count == 0);
        if (top && !top_prev) blink_m = blink_m + 5'd1;
        top_prev = top;
      end
      #1;
      while (!rst && q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.cur && bu[3]) pix = e.fg;
        else if (e.blk && bu[4]) pix = e.bg;
        else pix = e.pbit ? e.fg : e.bg;
        ec = e.von ? pix : 4'h0;
        checks++;
        if (color !== ec || e.due != cyc)
          $display("FAIL color cyc=%0d got=%h exp=%h", cyc, color, ec);
        else passed++;
        checks++;
        if (video_on_out !== e.von || e.due != cyc)
          $display("FAIL video_on_out cyc=%0d got=%b exp=%b",
                   cyc, video_on_out, e.von);
        else passed++;
      end
    end
  end

  task automatic drive(input int h, input int v, input bit von);
    exp_t e;
    int a;
    int px;
    logic [7:0] ch;
    logic [7:0] at;
    logic [7:0] fr;
    logic [3:0] sl;
    @(negedge clk);
    h_count  = 10'(h);
    v_count  = 10'(v);
    video_on = von;
    a  = ((v / 16) * 80 + h / 8) % 2048;
    sl = 4'(v % 16);
    px = h % 8;
    ch = char_mem[a];
    at = attr_mem[a];
    fr = font_mem[{ch, sl}];
    e.due  = cyc + 5;
    e.von  = von;
    e.pbit = fr[7 - px];
    e.blk  = at[7];
    e.fg   = at[3:0];
    e.bg   = {1'b0, at[6:4]};
    e.cur  = cursor_on && (a == int'(cursor_addr))
          && (cursor_start <= sl) && (sl <= cursor_end);
    q.push_back(e);
  endtask

  task automatic pulse();
    drive(0, 0, 0);
    drive(700, 450, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({text_addr, text_cs, font_addr, color, video_on_out} !== '0)
      $display("FAIL power_up_reset got=%h exp=0",
               {text_addr, text_cs, font_addr, color, video_on_out});
    else passed++;
    rst = 1'b0;
    drive(0, 0, 1);
    for (int i = 8; i < 16; i++) drive(i, 16, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    video_on = 1'b0;
    q.delete();
    #1;
    checks++;
    if (text_addr !== 11'd0) $display("FAIL rst_text_addr got=%0d exp=0", text_addr);
    else passed++;
    checks++;
    if (text_cs !== 1'b0) $display("FAIL rst_text_cs got=%b exp=0", text_cs);
    else passed++;
    checks++;
    if (font_addr !== 12'd0) $display("FAIL rst_font_addr got=%h exp=0", font_addr);
    else passed++;
    checks++;
    if (color !== 4'd0) $display("FAIL rst_color got=%h exp=0", color);
    else passed++;
    checks++;
    if (video_on_out !== 1'b0) $display("FAIL rst_video_on_out got=%b exp=0", video_on_out);
    else passed++;
    checks++;
    if (dut.blink_cnt !== 5'd0) $display("FAIL rst_blink_cnt got=%0d exp=0", dut.blink_cnt);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_cell();
    for (int i = 0; i < 4; i++) drive(i, 2, 1);
    checks++;
    if (font_addr !== 12'h412) $display("FAIL font_addr got=%h exp=412", font_addr);
    else passed++;
    drive(4, 2, 1);
    checks++;
    if (video_on_out !== 1'b0) $display("FAIL first_latency got=%b exp=0", video_on_out);
    else passed++;
    drive(5, 2, 1);
    checks++;
    if (video_on_out !== 1'b1 || color !== 4'hE)
      $display("FAIL first_pixel got=%b/%h exp=1/e", video_on_out, color);
    else passed++;
    drive(6, 2, 1);
    drive(7, 2, 1);
  endtask

  task automatic test_addressing();
    int ah [6] = '{639, 8, 639, 0, 320, 7};
    int av [6] = '{399, 16, 15, 16, 200, 0};
    int ea [6] = '{1999, 81, 79, 80, 1000, 0};
    for (int i = 0; i < 6; i++) begin
      drive(ah[i], av[i], 1);
      @(posedge clk);
      #1;
      checks++;
      if (text_addr !== 11'(ea[i]) || text_cs !== 1'b1)
        $display("FAIL addr h=%0d v=%0d got=%0d/%b exp=%0d/1",
                 ah[i], av[i], text_addr, text_cs, ea[i]);
      else passed++;
    end
  endtask

  task automatic test_blanking();
    bit pat [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      drive(16 + i, 5, pat[i]);
      @(posedge clk);
      #1;
      checks++;
      if (text_cs !== pat[i])
        $display("FAIL text_cs step=%0d got=%b exp=%b", i, text_cs, pat[i]);
      else passed++;
    end
  endtask

  task automatic test_blink();
    for (int i = 0; i < 40 && blink_m != 5'd16; i++) pulse();
    for (int h = 8; h < 16; h++) drive(h, 0, 1);
    for (int i = 0; i < 40 && blink_m != 5'd0; i++) pulse();
    for (int h = 8; h < 16; h++) drive(h, 0, 1);
  endtask

  task automatic test_cursor();
    cursor_on = 1'b1;
    cursor_addr = 11'd5;
    cursor_start = 4'd14;
    cursor_end = 4'd15;
    for (int i = 0; i < 40 && blink_m != 5'd8; i++) pulse();
    for (int h = 40; h < 48; h++) drive(h, 14, 1);
    for (int h = 40; h < 48; h++) drive(h, 15, 1);
    for (int h = 40; h < 48; h++) drive(h, 13, 1);
    cursor_start = 4'd15;
    cursor_end = 4'd14;
    for (int h = 40; h < 48; h++) drive(h, 14, 1);
    for (int h = 40; h < 48; h++) drive(h, 15, 1);
    cursor_addr = 11'd6;
    cursor_start = 4'd14;
    cursor_end = 4'd15;
    for (int i = 0; i < 40 && blink_m != 5'd24; i++) pulse();
    for (int h = 48; h < 56; h++) drive(h, 14, 1);
    for (int h = 48; h < 56; h++) drive(h, 13, 1);
  endtask

  task automatic test_random();
    cursor_addr = 11'd3;
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) begin
        cursor_start = 4'($urandom_range(0, 15));
        cursor_end = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) drive(0, 0, 1);
      else drive($urandom_range(0, 79), $urandom_range(0, 31),
                 $urandom_range(0, 9) != 0);
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    video_on = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) $display("FAIL drain left=%0d exp=0", q.size());
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      char_mem[i] = 8'($urandom);
      attr_mem[i] = 8'($urandom);
    end
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    char_mem[0] = 8'h41;
    attr_mem[0] = 8'h1E;
    font_mem[12'h412] = 8'h81;
    char_mem[1] = 8'h42;
    attr_mem[1] = 8'h9F;
    char_mem[5] = 8'h43;
    attr_mem[5] = 8'h07;
    char_mem[6] = 8'h43;
    attr_mem[6] = 8'h87;
    for (int i = 0; i < 16; i++) begin
      font_mem[12'h420 + i] = 8'hFF;
      font_mem[12'h430 + i] = 8'h00;
    end
    test_reset();
    test_single_cell();
    test_addressing();
    test_blanking();
    test_blink();
    test_cursor();
    test_random();
    test_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_rd.md
# vga_text_rd

Display-side reader for the VGA text-mode memories. It walks the 80x25 character RAM and the attribute RAM (a shared 11-bit address, written by the CPU side) together with the 8x16 font ROM. It emits one 4-bit color index per pixel for the 640x400 active area. It sits between the sync/counter generator and the DAC palette stage, and owns all display-side read ports of the text memories.

## Interface
Parameters:
- none (80 columns, 25 rows, 8x16 cells fixed)

Ports:
- clk  in  1  system clock; one pixel per cycle
- rst  in  1  reset; asynchronous, active-high
- h_count  in  10  pixel column from the sync generator, 0..639 in the active area
- v_count  in  10  pixel row, 0..399 in the active area
- video_on  in  1  high while h_count/v_count are inside the active area
- cursor_on  in  1  cursor enable
- cursor_addr  in  11  cell address of the cursor
- cursor_start  in  4  first cursor scanline within the cell
- cursor_end  in  4  last cursor scanline within the cell
- text_addr  out  11  shared address to the char and attr RAMs
- text_cs  out  1  read enable to the char and attr RAMs
- char_data  in  8  char RAM read data; synchronous, 1-cycle
- attr_data  in  8  attr RAM read data; synchronous, 1-cycle
- font_addr  out  12  font ROM address, {char, scanline[3:0]}
- font_data  in  8  font ROM row; bit 7 is the leftmost pixel; synchronous, 1-cycle
- color  out  4  pixel color index
- video_on_out  out  1  video_on delayed to align with color

## Operation
- S0, edge k:
  - text_addr <= v_count[8:4]*80 + h_count[9:3].
  - Implement the multiply as (r<<6)+(r<<4); no multiplier.
  - Valid range is 0..1999; addresses 2000..2047 are never generated while video_on=1.
  - text_cs <= video_on.
  - Also register the S0 context: scanline v_count[3:0], px = h_count[2:0], video_on, and the cursor match.
  - cursor match = cursor_on && addr==cursor_addr && cursor_start<=scanline<=cursor_end.
  - If cursor_start > cursor_end, the cursor is never shown.
- Edge k+1: the RAMs sample text_addr.
- S2, edge k+2:
  - font_addr <= {char_data, scanline}.
  - Capture attr_data into the pipeline.
  - Carry px, video_on and cursor match forward.
- Edge k+3: the ROM samples font_addr.
- S4, edge k+4: compute the pixel.
  - bit = font_data[7-px].
  - fg = attr[3:0]; bg = {1'b0, attr[6:4]}.
  - If attr[7]=1 and blink_cnt[4]=1, the pixel is background regardless of bit.
  - If the cursor matches and blink_cnt[3]=1, the pixel is fg.
  - Otherwise the pixel is bit ? fg : bg.
  - color <= video_on_d ? pixel : 0; video_on_out <= video_on_d.
- Blink counter:
  - 5-bit blink_cnt increments once per frame.
  - Increment condition: the cycle with h_count==0 && v_count==0 while the previous cycle was not that state.
  - Wraps 31 -> 0.
- Context registers shift every cycle; there is no stall and no handshake. The RAMs are read-only from this side.

## Timing
- Latency is 4 cycles: the inputs sampled at edge k produce color and video_on_out after edge k+4.
- Reset (asynchronous): text_addr=0, text_cs=0, font_addr=0, color=0, video_on_out=0, blink_cnt=0, and all pipeline context cleared (video_on_d=0).
- Reset mid-frame: outputs go to their reset values immediately. After release, the first valid color appears 4 cycles after video_on is first sampled high.
- Boundaries:
  - h_count 639 -> 0 at a line wrap is handled purely by the address recompute; there is no carry state.
  - v_count 15 -> 16 advances the cell row by 80.
- video_on low: text_cs=0 one cycle later; color=0 four cycles later. text_addr keeps its computed value (do not care).
- Blink and cursor may coincide on the same pixel: the cursor wins (fg).

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs are 0 at once; blink_cnt=0.
- Single cell: char RAM[0]=0x41, attr[0]=0x1E, font[0x412]=0x81, drive h=0..7, v=2, video_on=1.
  - Required response, four cycles later: color = 0xE,1,1,1,1,1,1,0xE.
  - font_addr=0x412 is seen at edge k+2.
- Addressing:
  - h=639, v=399 -> text_addr=1999.
  - h=8, v=16 -> 81.
  - h=639, v=15 -> 79.
- Blink: attr=0x9F, font row 0xFF, run 16 frames so that blink_cnt[4]=1 -> color=0x1. At blink_cnt=0 -> 0xF.
- Cursor: cursor_on=1, cursor_addr=5, start=14, end=15, blink_cnt=8, font row 0x00, attr=0x07.
  - Scanlines 14/15 of cell 5 -> color=7.
  - Scanline 13 -> 0.
  - start=15, end=14 -> never 7.
- Blanking: drop video_on for 3 cycles -> text_cs low after 1 cycle, color=0 and video_on_out=0 for exactly 3 cycles starting 4 cycles later.
